// File: rtl/rr_grant_scheduler_4_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : rr_grant_scheduler_4_pkg
//  Purpose  : Shared constants, state encoding and the round-robin pick
//             helper for the 4-requester grant scheduler.
//  Revision : 1.0 - initial release
// ============================================================================
package rr_grant_scheduler_4_pkg;

    localparam int c_N_REQ        = 4;
    localparam int c_IDX_W        = 2;
    localparam int c_DEF_MAX_HOLD = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_GRANT = 2'b01,
        ST_TURN  = 2'b10
    } state_t;

    typedef struct packed {
        logic               valid;
        logic [c_IDX_W-1:0] id;
    } pick_t;

    // Scan LAST+1, LAST+2, LAST+3, LAST (mod 4); the first set request wins.
    // The previous owner is visited last, so it only re-wins when alone.
    function automatic pick_t rr_pick(input logic [c_N_REQ-1:0] req,
                                      input logic [c_IDX_W-1:0] last);
        pick_t              p;
        logic [c_IDX_W-1:0] idx;
        p.valid = 1'b0;
        p.id    = last;
        for (int k = 1; k <= c_N_REQ; k++) begin
            idx = last + c_IDX_W'(k);
            if (!p.valid && req[idx]) begin
                p.valid = 1'b1;
                p.id    = idx;
            end
        end
        return p;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_grant_scheduler_4_if.sv
`default_nettype none
// ============================================================================
//  Module   : rr_grant_scheduler_4_if
//  Purpose  : Request/grant bundle between requesters and the scheduler.
//  Signals  : EN      - global enable (blocks new grants only)
//             REQ     - level request per requester
//             GNT     - one-hot grant, zero when idle
//             GNT_ID  - index of current/last owner
//             BUSY    - high while a grant is held
//             TIMEOUT - one-cycle pulse on forced revoke
//  Modports : master (requester side), slave (scheduler side)
//  Revision : 1.0 - initial release
// ============================================================================
interface rr_grant_scheduler_4_if;
    import rr_grant_scheduler_4_pkg::*;

    logic                EN;
    logic [c_N_REQ-1:0]  REQ;
    logic [c_N_REQ-1:0]  GNT;
    logic [c_IDX_W-1:0]  GNT_ID;
    logic                BUSY;
    logic                TIMEOUT;

    modport master (output EN, REQ, input GNT, GNT_ID, BUSY, TIMEOUT);
    modport slave  (input EN, REQ, output GNT, GNT_ID, BUSY, TIMEOUT);

endinterface
`default_nettype wire

// File: rtl/rr_grant_scheduler_4_onehot_dec.sv
`default_nettype none
// ============================================================================
//  Module   : rr_onehot_dec
//  Purpose  : 2-to-4 decoder with enable, gate-level style.
//  Ports    : i_en         - enable; all outputs low when 0
//             i_a1         - select bit 0 (LSB)
//             i_a2         - select bit 1 (MSB)
//             o_d0..o_d3   - decoded outputs, o_dN high for select == N
//  Revision : 1.0 - initial release
// ============================================================================
module rr_onehot_dec (
    input  wire logic i_en,
    input  wire logic i_a1,
    input  wire logic i_a2,
    output wire logic o_d0,
    output wire logic o_d1,
    output wire logic o_d2,
    output wire logic o_d3
);

    assign o_d0 = i_en & ~i_a2 & ~i_a1;
    assign o_d1 = i_en & ~i_a2 &  i_a1;
    assign o_d2 = i_en &  i_a2 & ~i_a1;
    assign o_d3 = i_en &  i_a2 &  i_a1;

endmodule
`default_nettype wire

// File: rtl/rr_grant_scheduler_4.sv
`default_nettype none
// ============================================================================
//  Module   : rr_grant_scheduler_4
//  Purpose  : Round-robin scheduler sharing one resource among 4 requesters.
//             IDLE -> GRANT (held while owner requests) -> TURN (one dead
//             cycle) -> IDLE. GNT is the registered owner index decoded and
//             gated by the registered BUSY flag.
//  Ports    : CLK  - clock
//             RST  - synchronous active-high reset
//             bus  - rr_grant_scheduler_4_if.slave (EN, REQ, GNT, GNT_ID,
//                    BUSY, TIMEOUT)
//  Params   : MAX_HOLD - max consecutive grant cycles (timeout build only)
//             CNT_W    - hold counter width, 2**CNT_W > MAX_HOLD
//  Options  : RR_SCHED_TIMEOUT_EN - enables forced revoke after MAX_HOLD
//             cycles; otherwise TIMEOUT is tied low and grants are unbounded.
//  Revision : 1.0 - initial release
// ============================================================================
module rr_grant_scheduler_4
    import rr_grant_scheduler_4_pkg::*;
#(
    parameter int MAX_HOLD = c_DEF_MAX_HOLD,
    parameter int CNT_W    = 4
) (
    input  wire logic               CLK,
    input  wire logic               RST,
    rr_grant_scheduler_4_if.slave   bus
);

    if ((MAX_HOLD < 1) || (MAX_HOLD > 15) || ((2 ** CNT_W) <= MAX_HOLD)) begin : g_param_check
        $error("rr_grant_scheduler_4: illegal MAX_HOLD/CNT_W combination");
    end

    state_t             r_state;
    logic [c_IDX_W-1:0] r_gnt_id;
    logic [c_IDX_W-1:0] r_last;
    logic               r_busy;
    logic               r_timeout;
`ifdef RR_SCHED_TIMEOUT_EN
    logic [CNT_W-1:0]   r_hold;
`endif

    pick_t              w_pick;
    logic               w_owner_req;
    logic [c_N_REQ-1:0] w_gnt;

    always_comb begin
        w_pick      = rr_pick(bus.REQ, r_last);
        w_owner_req = bus.REQ[r_gnt_id];
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state   <= ST_IDLE;
            r_gnt_id  <= '0;
            r_last    <= 2'b11;     // requester 0 gets first priority
            r_busy    <= 1'b0;
            r_timeout <= 1'b0;
`ifdef RR_SCHED_TIMEOUT_EN
            r_hold    <= '0;
`endif
        end else begin
            r_timeout <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.EN && w_pick.valid) begin
                        r_state  <= ST_GRANT;
                        r_gnt_id <= w_pick.id;
                        r_last   <= w_pick.id;
                        r_busy   <= 1'b1;
`ifdef RR_SCHED_TIMEOUT_EN
                        r_hold   <= '0;
`endif
                    end
                end
                ST_GRANT: begin
                    // EN is deliberately ignored here: the owner keeps its
                    // grant until it releases the request.
                    if (!w_owner_req) begin
                        r_state <= ST_TURN;
                        r_busy  <= 1'b0;
`ifdef RR_SCHED_TIMEOUT_EN
                        r_hold  <= '0;
`endif
                    end
`ifdef RR_SCHED_TIMEOUT_EN
                    else if (r_hold == CNT_W'(MAX_HOLD - 1)) begin
                        // Forced revoke; LAST keeps this ID so it ranks last.
                        r_state   <= ST_TURN;
                        r_busy    <= 1'b0;
                        r_hold    <= '0;
                        r_timeout <= 1'b1;
                    end else if (r_hold != {CNT_W{1'b1}}) begin
                        r_hold <= r_hold + CNT_W'(1);
                    end
`endif
                end
                ST_TURN: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    rr_onehot_dec u_dec (
        .i_en (r_busy),
        .i_a1 (r_gnt_id[0]),
        .i_a2 (r_gnt_id[1]),
        .o_d0 (w_gnt[0]),
        .o_d1 (w_gnt[1]),
        .o_d2 (w_gnt[2]),
        .o_d3 (w_gnt[3])
    );

    assign bus.GNT     = w_gnt;
    assign bus.GNT_ID  = r_gnt_id;
    assign bus.BUSY    = r_busy;
    assign bus.TIMEOUT = r_timeout;

endmodule
`default_nettype wire
